// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the RV32I program loader: instruction formats,
// loader error codes, FSM states and base opcodes.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_IMM_RANGE = 2'd1,
        ERR_IMM_ALIGN = 2'd2,
        ERR_ADDR_OVF  = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational RV32I field packer: scatters the immediate into the
// selected format and flags immediates that cannot be encoded.
module rv32_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic [1:0]  o_err
);

    logic signed [31:0] w_simm;
    assign w_simm = $signed(i_imm);

    always_comb begin
        o_word = '0;
        o_err  = ERR_NONE;
        unique case (i_fmt)
            FMT_R: begin
                o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_I: begin
                if (w_simm < -32'sd2048 || w_simm > 32'sd2047)
                    o_err = ERR_IMM_RANGE;
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_S: begin
                if (w_simm < -32'sd2048 || w_simm > 32'sd2047)
                    o_err = ERR_IMM_RANGE;
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:0], i_opcode};
            end
            FMT_B: begin
                // Range is checked before alignment
                if (w_simm < -32'sd4096 || w_simm > 32'sd4094)
                    o_err = ERR_IMM_RANGE;
                else if (i_imm[0])
                    o_err = ERR_IMM_ALIGN;
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
            end
            FMT_U: begin
                if (i_imm[11:0] != 12'd0)
                    o_err = ERR_IMM_ALIGN;
                o_word = {i_imm[31:12], i_rd, i_opcode};
            end
            FMT_J: begin
                if (w_simm < -32'sd1048576 || w_simm > 32'sd1048574)
                    o_err = ERR_IMM_RANGE;
                else if (i_imm[0])
                    o_err = ERR_IMM_ALIGN;
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                          i_rd, i_opcode};
            end
            default: begin
                o_err = ERR_IMM_ALIGN;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader FSM: accepts field bundles, encodes them and writes
// the words sequentially into imem through a write/ack handshake.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [15:0]       count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_count;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic [1:0]        r_err_code;

    logic [31:0]       w_word;
    logic [1:0]        w_pack_err;
    logic              w_load;
    logic              w_take;
    logic              w_ack;
    logic              w_err_wr;
    logic [1:0]        w_err_val;
    logic              w_at_end;

    rv32_field_packer u_packer (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_err    (w_pack_err)
    );

    assign w_at_end = (r_addr == ADDR_W'(MEM_BYTES - 4));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_take    = 1'b0;
        w_ack     = 1'b0;
        w_err_wr  = 1'b0;
        w_err_val = ERR_NONE;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (r_state == S_DONE) w_next = S_IDLE;
                if (start) begin
                    w_load   = 1'b1;
                    w_err_wr = 1'b1;
                    if (base_addr[1:0] != 2'b00) begin
                        w_next    = S_ERROR;
                        w_err_val = ERR_ADDR_OVF;
                    end else begin
                        w_next = S_ACCEPT;
                    end
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (w_pack_err != ERR_NONE) begin
                        w_next    = S_ERROR;
                        w_err_wr  = 1'b1;
                        w_err_val = w_pack_err;
                    end else begin
                        w_take = 1'b1;
                        w_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    w_ack = 1'b1;
                    if (r_last) begin
                        w_next = S_DONE;
                    end else if (w_at_end) begin
                        w_next    = S_ERROR;
                        w_err_wr  = 1'b1;
                        w_err_val = ERR_ADDR_OVF;
                    end else begin
                        w_next = S_ACCEPT;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Abort wins over any pending ack or start
        if (abort) begin
            w_next    = S_IDLE;
            w_load    = 1'b0;
            w_take    = 1'b0;
            w_ack     = 1'b0;
            w_err_wr  = 1'b1;
            w_err_val = ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_wdata    <= '0;
            r_last     <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_load) begin
                r_addr  <= base_addr;
                r_count <= '0;
            end
            if (w_take) begin
                r_wdata <= w_word;
                r_last  <= in_last;
            end
            if (w_ack) begin
                r_addr  <= r_addr + ADDR_W'(4);
                r_count <= r_count + 16'd1;
            end
            if (w_err_wr) r_err_code <= w_err_val;
        end
    end

    assign in_ready  = (r_state == S_ACCEPT);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);
    assign err_code  = r_err_code;

endmodule
